im_burst_mem: RTL and testbench

Parametrised instruction/data memory model with a configurable wait-state count and a multi-beat read burst, the next-generation successor to the fixed two-wait-state instruction memory. It sits between the core's fetch unit (or the cache refill path) and the memory map. It accepts one request at a time through a request/busy handshake. Read requests return BURST_LEN consecutive words, one per cycle. Write requests are single-beat with byte enables.

---
 rtl/im_burst_mem.sv | 164 ++++++++++++++++
 tb/tb_im_burst_mem.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/im_burst_mem.sv
// Instruction/data memory model with programmable wait states and multi-beat read bursts.
// Define IM_WRAP_BURST_EN for critical-word-first bursts that wrap within the aligned block.
module im_burst_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 14,
    parameter int unsigned MEM_DEPTH  = 4096,
    parameter int unsigned WAIT_STATE = 2,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    IM_req,
    input  logic                    IM_write,
    input  logic [ADDR_BITS-1:0]    IM_address,
    input  logic [DATA_WIDTH-1:0]   IM_in,
    input  logic [DATA_WIDTH/8-1:0] IM_be,
    output logic [DATA_WIDTH-1:0]   IM_out,
    output logic                    IM_ready,
    output logic                    IM_last,
    output logic                    IM_busy,
    output logic                    IM_wack
);

    localparam int unsigned NumBytes  = DATA_WIDTH / 8;
    localparam int unsigned ByteShift = $clog2(NumBytes);
    localparam int unsigned WordW     = ADDR_BITS - ByteShift;
    localparam int unsigned IdxW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned BeatW     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [WordW-1:0] BlkMask  = WordW'(BURST_LEN - 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);
    localparam logic [3:0]       WaitLoad = (WAIT_STATE > 0) ? 4'(WAIT_STATE - 1) : 4'd0;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StBurst,
        StWcommit
    } state_e;

    state_e                  r_state;
    logic [3:0]              r_wait;
    logic [BeatW-1:0]        r_beat;
    logic [WordW-1:0]        r_word;
    logic                    r_write;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [NumBytes-1:0]     r_be;
    logic [DATA_WIDTH-1:0]   r_out;
    logic                    r_ready;
    logic                    r_last;
    logic                    r_wack;

    logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

    logic [WordW-1:0]        w_req_word;
    logic [WordW-1:0]        w_base;
    logic [WordW-1:0]        w_beat_word;
    logic [IdxW-1:0]         w_rd_idx;
    logic [IdxW-1:0]         w_wr_idx;
    logic                    w_commit;
    logic                    w_unused_lsbs;

    function automatic logic [IdxW-1:0] to_idx(input logic [WordW-1:0] word);
        return IdxW'(32'(word) % MEM_DEPTH);
    endfunction

    // Byte offset within a word never selects storage.
    assign w_unused_lsbs = ^IM_address[ByteShift-1:0];
    assign w_req_word    = IM_address[ADDR_BITS-1:ByteShift];
    assign w_base        = r_word & ~BlkMask;

`ifdef IM_WRAP_BURST_EN
    assign w_beat_word = w_base | ((r_word + WordW'(r_beat)) & BlkMask);
`else
    assign w_beat_word = w_base | WordW'(r_beat);
`endif

    assign w_rd_idx = to_idx(w_beat_word);
    assign w_wr_idx = to_idx(r_word);
    // First WCOMMIT cycle is the commit edge; the second only holds busy over the wack pulse.
    assign w_commit = (r_state == StWcommit) && !r_wack;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
            r_wait  <= 4'd0;
            r_beat  <= '0;
            r_word  <= '0;
            r_write <= 1'b0;
            r_data  <= '0;
            r_be    <= '0;
            r_out   <= '0;
            r_ready <= 1'b0;
            r_last  <= 1'b0;
            r_wack  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_ready <= 1'b0;
                    r_last  <= 1'b0;
                    r_wack  <= 1'b0;
                    if (IM_req) begin
                        r_word  <= w_req_word;
                        r_write <= IM_write;
                        r_data  <= IM_in;
                        r_be    <= IM_be;
                        r_wait  <= WaitLoad;
                        r_beat  <= '0;
                        if (WAIT_STATE > 0) begin
                            r_state <= StWait;
                        end else begin
                            r_state <= IM_write ? StWcommit : StBurst;
                        end
                    end
                end
                StWait: begin
                    if (r_wait == 4'd0) begin
                        r_state <= r_write ? StWcommit : StBurst;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                StBurst: begin
                    r_out   <= r_mem[w_rd_idx];
                    r_ready <= 1'b1;
                    r_last  <= (r_beat == LastBeat);
                    // Leaving on the last-beat edge allows the next accept one edge later.
                    if (r_beat == LastBeat) begin
                        r_state <= StIdle;
                    end else begin
                        r_beat <= r_beat + BeatW'(1);
                    end
                end
                StWcommit: begin
                    if (!r_wack) begin
                        r_wack <= 1'b1;
                    end else begin
                        r_wack  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Storage is never reset; a reset on the commit edge drops the write.
    always_ff @(posedge clock) begin
        if (w_commit && !reset) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (r_be[i]) begin
                    r_mem[w_wr_idx][i*8 +: 8] <= r_data[i*8 +: 8];
                end
            end
        end
    end

    assign IM_out   = r_out;
    assign IM_ready = r_ready;
    assign IM_last  = r_last;
    assign IM_busy  = (r_state != StIdle);
    assign IM_wack  = r_wack;

endmodule

// File: tb/tb_im_burst_mem.sv
// Directed bench for im_burst_mem: default build (WS=2, BL=4) and a WS=0, BL=1 instance.
module tb_im_burst_mem;

    logic        clock = 1'b0;
    logic        reset;

    logic        req, wr;
    logic [13:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic [31:0] dout;
    logic        ready, last, busy, wack;

    logic        s_req, s_wr;
    logic [13:0] s_addr;
    logic [31:0] s_din;
    logic [3:0]  s_be;
    logic [31:0] s_dout;
    logic        s_ready, s_last, s_busy, s_wack;

    int checks = 0;
    int errors = 0;

`ifdef IM_WRAP_BURST_EN
    localparam logic [127:0] Exp48 = {32'd2, 32'd1, 32'd4, 32'd3};
    localparam logic [127:0] Exp44 = {32'd1, 32'd4, 32'd3, 32'd2};
`else
    localparam logic [127:0] Exp48 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] Exp44 = {32'd4, 32'd3, 32'd2, 32'd1};
`endif
    localparam logic [127:0] Exp40 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] Exp10 = {32'h66666666, 32'h55555555, 32'h11BBCC44, 32'hDEADBEAA};

    always #5 clock = ~clock;

    im_burst_mem dut (
        .clock      (clock),
        .reset      (reset),
        .IM_req     (req),
        .IM_write   (wr),
        .IM_address (addr),
        .IM_in      (din),
        .IM_be      (be),
        .IM_out     (dout),
        .IM_ready   (ready),
        .IM_last    (last),
        .IM_busy    (busy),
        .IM_wack    (wack)
    );

    im_burst_mem #(
        .DATA_WIDTH (32),
        .ADDR_BITS  (14),
        .MEM_DEPTH  (256),
        .WAIT_STATE (0),
        .BURST_LEN  (1)
    ) dut_s (
        .clock      (clock),
        .reset      (reset),
        .IM_req     (s_req),
        .IM_write   (s_wr),
        .IM_address (s_addr),
        .IM_in      (s_din),
        .IM_be      (s_be),
        .IM_out     (s_dout),
        .IM_ready   (s_ready),
        .IM_last    (s_last),
        .IM_busy    (s_busy),
        .IM_wack    (s_wack)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [13:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; wr = 1'b1; addr = a; din = d; be = b;
        tick();
        req = 1'b0; wr = 1'b0;
        check_bit("wr_busy_rise", busy, 1'b1);
        check_bit("wr_wack_t0", wack, 1'b0);
        tick();
        check_bit("wr_wack_t1", wack, 1'b0);
        tick();
        check_bit("wr_wack_t2", wack, 1'b0);
        tick();
        check_bit("wr_wack_t3", wack, 1'b1);
        check_bit("wr_busy_t3", busy, 1'b1);
        tick();
        check_bit("wr_wack_t4", wack, 1'b0);
        check_bit("wr_busy_t4", busy, 1'b0);
    endtask

    task automatic do_read(input logic [13:0] a, input logic [127:0] exp, input bit pulse);
        req = 1'b1; wr = 1'b0; addr = a;
        tick();
        req = 1'b0;
        check_bit("rd_busy_rise", busy, 1'b1);
        check_bit("rd_ready_t0", ready, 1'b0);
        if (pulse) begin
            // A write request while busy must be dropped.
            req = 1'b1; wr = 1'b1; din = 32'hFFFFFFFF; be = 4'hF;
        end
        tick();
        req = 1'b0; wr = 1'b0;
        check_bit("rd_ready_t1", ready, 1'b0);
        tick();
        check_bit("rd_ready_t2", ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_bit("rd_beat_ready", ready, 1'b1);
            check_word("rd_beat_data", dout, exp[k*32 +: 32]);
            check_bit("rd_beat_last", last, (k == 3));
        end
        check_bit("rd_busy_fall", busy, 1'b0);
        tick();
        check_bit("rd_ready_after", ready, 1'b0);
        check_bit("rd_last_after", last, 1'b0);
        check_word("rd_out_hold", dout, exp[127:96]);
    endtask

    initial begin
        reset = 1'b1;
        req = 1'b0; wr = 1'b0; addr = '0; din = '0; be = '0;
        s_req = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0; s_be = '0;
        tick();
        tick();
        check_word("rst_out", dout, 32'd0);
        check_bit("rst_ready", ready, 1'b0);
        check_bit("rst_last", last, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_wack", wack, 1'b0);
        check_word("s_rst_out", s_dout, 32'd0);
        check_bit("s_rst_busy", s_busy, 1'b0);
        check_bit("s_rst_ready", s_ready, 1'b0);
        reset = 1'b0;
        tick();
        check_bit("idle_busy", busy, 1'b0);

        // Full and partial byte-enable writes, then a read of the block.
        do_write(14'h10, 32'hDEADBEEF, 4'hF);
        do_write(14'h10, 32'h000000AA, 4'h1);
        do_write(14'h14, 32'h11223344, 4'hF);
        do_write(14'h14, 32'hAABBCCDD, 4'h6);
        do_write(14'h18, 32'h55555555, 4'hF);
        do_write(14'h1C, 32'h66666666, 4'hF);
        do_read(14'h10, Exp10, 1'b0);

        do_write(14'h40, 32'd1, 4'hF);
        do_write(14'h44, 32'd2, 4'hF);
        do_write(14'h48, 32'd3, 4'hF);
        do_write(14'h4C, 32'd4, 4'hF);
        do_read(14'h48, Exp48, 1'b0);
        do_read(14'h44, Exp44, 1'b1);
        do_read(14'h40, Exp40, 1'b0);

        // Reset during beat 1 aborts the burst.
        req = 1'b1; wr = 1'b0; addr = 14'h40;
        tick();
        req = 1'b0;
        tick();
        tick();
        tick();
        check_word("mid_beat0", dout, 32'd1);
        tick();
        check_word("mid_beat1", dout, 32'd2);
        check_bit("mid_busy_pre", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_bit("mid_rst_ready", ready, 1'b0);
        check_bit("mid_rst_busy", busy, 1'b0);
        check_bit("mid_rst_last", last, 1'b0);
        check_word("mid_rst_out", dout, 32'd0);
        tick();
        do_read(14'h48, Exp48, 1'b0);

        // Zero wait states, single-beat bursts.
        s_req = 1'b1; s_wr = 1'b1; s_addr = 14'h4; s_din = 32'h12345678; s_be = 4'hF;
        tick();
        s_req = 1'b0; s_wr = 1'b0;
        check_bit("s_wr_busy", s_busy, 1'b1);
        check_bit("s_wr_wack0", s_wack, 1'b0);
        tick();
        check_bit("s_wr_wack1", s_wack, 1'b1);
        tick();
        check_bit("s_wr_wack2", s_wack, 1'b0);
        check_bit("s_wr_busy2", s_busy, 1'b0);

        s_req = 1'b1; s_wr = 1'b0; s_addr = 14'h4;
        tick();
        check_bit("s_rd_busy0", s_busy, 1'b1);
        check_bit("s_rd_ready0", s_ready, 1'b0);
        tick();
        check_bit("s_rd_ready1", s_ready, 1'b1);
        check_bit("s_rd_last1", s_last, 1'b1);
        check_word("s_rd_data1", s_dout, 32'h12345678);
        check_bit("s_rd_busy1", s_busy, 1'b0);
        tick();
        s_req = 1'b0;
        check_bit("s_rd2_busy", s_busy, 1'b1);
        check_bit("s_rd2_ready0", s_ready, 1'b0);
        check_word("s_rd2_hold", s_dout, 32'h12345678);
        tick();
        check_bit("s_rd2_ready", s_ready, 1'b1);
        check_bit("s_rd2_last", s_last, 1'b1);
        tick();
        check_bit("s_rd2_ready_after", s_ready, 1'b0);
        check_bit("s_rd2_busy_after", s_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
